lut_loader: RTL

Write-side companion to the main 256x8 registered-output LUT. It accepts a byte stream over a valid/ready handshake and writes it sequentially into LUT addresses 0..DEPTH-1. It then reads the whole table back through the LUT's registered read port and compares a modular checksum of the read-back data against the checksum of the written data. It sits between the configuration source (host/UART/ROM stream) and the LUT's write/address port, and owns that port exclusively while busy.

---
 rtl/lut_loader.sv | 112 +++++++++++
 1 files changed

// File: rtl/lut_loader.sv
// Streams DEPTH bytes into the LUT write port, reads the table back through the
// registered read port and flags a checksum mismatch between written and read data.
module lut_loader #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8,
    parameter int DEPTH  = 2**ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              lut_we,
    output logic [ADDR_W-1:0] lut_a,
    output logic [DATA_W-1:0] lut_d,
    input  logic [DATA_W-1:0] lut_qspo,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [DATA_W-1:0] chk_sum
);

    typedef enum logic [2:0] {IDLE, LOAD, SETTLE, VERIFY, DRAIN, DONE} state_t;

    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

    state_t            state, state_nxt;
    logic              beat;
    logic              rd_vld;
    logic [ADDR_W-1:0] wr_cnt, rd_cnt;
    logic [DATA_W-1:0] wr_sum, rd_sum, rd_sum_nxt;

    assign beat       = in_valid & in_ready;
    assign rd_sum_nxt = rd_sum + (rd_vld ? lut_qspo : '0);

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = LOAD;
            LOAD:    if (beat && wr_cnt == LAST) state_nxt = SETTLE;
            SETTLE:  state_nxt = VERIFY;
            VERIFY:  if (lut_a == LAST) state_nxt = DRAIN;
            DRAIN:   state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        in_ready = 1'b0;
        busy     = 1'b0;
        done     = 1'b0;
        case (state)
            LOAD:                  begin in_ready = 1'b1; busy = 1'b1; end
            SETTLE, VERIFY, DRAIN: busy = 1'b1;
            DONE:                  done = 1'b1;
            default:               ;
        endcase
    end

    // rd_vld marks the cycle in which lut_qspo holds data for the address presented one cycle earlier
    always_ff @(posedge clk) begin
        if (rst) begin
            lut_we  <= 1'b0;
            lut_a   <= '0;
            lut_d   <= '0;
            err     <= 1'b0;
            chk_sum <= '0;
            wr_sum  <= '0;
            rd_sum  <= '0;
            wr_cnt  <= '0;
            rd_cnt  <= '0;
            rd_vld  <= 1'b0;
        end else begin
            lut_we <= beat;
            rd_vld <= (state == VERIFY);
            if (rd_vld) rd_sum <= rd_sum_nxt;
            case (state)
                IDLE: if (start) begin
                    wr_sum <= '0;
                    rd_sum <= '0;
                    wr_cnt <= '0;
                    rd_cnt <= '0;
                    err    <= 1'b0;
                end
                LOAD: if (beat) begin
                    lut_a  <= wr_cnt;
                    lut_d  <= in_data;
                    wr_cnt <= wr_cnt + 1'b1;
                    wr_sum <= wr_sum + in_data;
                end
                SETTLE, VERIFY: begin
                    lut_a  <= rd_cnt;
                    rd_cnt <= rd_cnt + 1'b1;
                end
                // the last read sample lands this cycle, so fold it in before comparing
                DRAIN: begin
                    chk_sum <= wr_sum;
                    err     <= (rd_sum_nxt != wr_sum);
                end
                default: ;
            endcase
        end
    end

endmodule
